count_seq_checker: RTL
======================

Name: count_seq_checker

Overview:
- Receive-side partner of the 8-bit free-running counter source.
- Samples a counter stream arriving on a parallel bus and checks that each sample equals the previous sample + 1, modulo 2^WIDTH.
- Acquires lock after a run of correct increments and reports mismatches as a pulse and as a saturating error count.
- Drops lock after repeated consecutive misses; used for on-chip loopback self-test of counter outputs.

Parameters:
- WIDTH, 8: data and counter width in bits.
- LOCK_CNT, 4: consecutive correct increments required to enter LOCKED (range 1..15).
- LOSS_CNT, 3: consecutive mismatches in LOCKED that force re-acquisition (range 1..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn_n  in  1  reset, asynchronous, active-low.
- en  in  1  sample strobe; din is consumed only on cycles with en=1.
- clr  in  1  synchronous clear: FSM to IDLE, err_count to 0; has priority over en.
- din  in  WIDTH  incoming counter value.
- locked  out  1  high while FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED.
- err_count  out  8  saturating count of mismatches in LOCKED; holds at 255.
- last_val  out  WIDTH  most recently accepted sample.
- state  out  2  encoded state: 0=IDLE, 1=ACQ, 2=LOCKED.

Behaviour:
- Reset (rstn_n low, async): state=IDLE, locked=0, err_pulse=0, err_count=0, last_val=0, internal match/miss counters=0.
- All outputs are registered. A sample taken at edge N is reflected on the outputs immediately after edge N (one-cycle latency from din valid).
- expected = last_val + 1, truncated to WIDTH bits. The value 2^WIDTH-1 followed by 0 is a correct increment.
- Cycles with en=0: no state change, and err_pulse=0.
- clr=1: state=IDLE, match=0, miss=0, err_count=0, err_pulse=0. last_val is held. en is ignored in the same cycle.
- IDLE, en=1: last_val<=din, match=0, go ACQ. This first sample is never an error.
- ACQ, en=1:
  - last_val<=din on every accepted sample.
  - din==expected: match++. When match reaches LOCK_CNT, go LOCKED with miss=0.
  - din!=expected: match=0, stay ACQ. No err_pulse and no err_count change while in ACQ.
- LOCKED, en=1:
  - last_val<=din always; the checker re-seeds on a bad value.
  - din==expected: miss=0.
  - din!=expected: err_pulse=1 for one cycle, err_count++ (saturating at 255), miss++. When miss reaches LOSS_CNT, go ACQ with match=0 and locked=0 after that edge.
- locked = (state==LOCKED), registered.
- err_count saturation: at 255 further mismatches still pulse err_pulse, and the count stays 255.
- Async reset asserted mid-stream: immediate return to reset values. The first sample after release is treated as in IDLE.

Test Plan:
- Lock: after reset, en=1 with din=10,11,12,13,14 on consecutive cycles -> state IDLE→ACQ after 10; locked=1 after the edge sampling 14; err_count=0.
- Wrap: locked stream 253,254,255,0,1 -> no err_pulse, locked stays 1, last_val=1.
- Single glitch: locked stream 20,21,99,100,101 -> one err_pulse on the cycle after 99 is sampled; err_count=1; locked remains 1 because 100 matches re-seeded 99+1.
- Loss of lock (LOSS_CNT=3): locked, then din=5,50,7,90 -> three err_pulses; locked=0 and state=ACQ after the third mismatch; err_count=3.
- en gating and clr: locked at last_val=40, en=0 with din=77 for 5 cycles -> no change. Then clr=1 with en=1 -> state=IDLE, err_count=0, last_val=40.
- Saturation and async reset: force 260 mismatches while locked (LOSS_CNT=15, re-lock between bursts) -> err_count=255 and not wrapped. Assert rstn_n low mid-cycle -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/count_seq_checker.sv
// Receive-side checker for a free-running counter stream: locks after a run of
// correct increments, flags mismatches while locked, and drops lock on repeated misses.
module count_seq_checker #(
   parameter int WIDTH    = 8,
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3
) (
   input  logic             clk,
   input  logic             rstn_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic             locked,
   output logic             err_pulse,
   output logic [7:0]       err_count,
   output logic [WIDTH-1:0] last_val,
   output logic [1:0]       state
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACQ    = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

   logic [1:0]       state_q, state_d;
   logic [3:0]       match_q, match_d;
   logic [3:0]       miss_q, miss_d;
   logic [7:0]       err_count_q, err_count_d;
   logic             err_pulse_q, err_pulse_d;
   logic             locked_q, locked_d;
   logic [WIDTH-1:0] last_val_q, last_val_d;

   logic [WIDTH-1:0] expected;
   logic             hit;

   assign expected = last_val_q + WIDTH'(1);
   assign hit      = (din == expected);

   // en is a one-cycle sample strobe: din is consumed on every rising edge with
   // en=1 and clr=0; there is no back-pressure.
   always_comb begin
      state_d     = state_q;
      match_d     = match_q;
      miss_d      = miss_q;
      err_count_d = err_count_q;
      err_pulse_d = 1'b0;
      last_val_d  = last_val_q;

      if (clr) begin
         state_d     = ST_IDLE;
         match_d     = 4'd0;
         miss_d      = 4'd0;
         err_count_d = 8'd0;
      end else if (en) begin
         last_val_d = din;
         case (state_q)
            ST_IDLE: begin
               match_d = 4'd0;
               miss_d  = 4'd0;
               state_d = ST_ACQ;
            end
            ST_ACQ: begin
               if (hit) begin
                  if (match_q + 4'd1 == LOCK_TGT) begin
                     state_d = ST_LOCKED;
                     match_d = 4'd0;
                     miss_d  = 4'd0;
                  end else begin
                     match_d = match_q + 4'd1;
                  end
               end else begin
                  match_d = 4'd0;
               end
            end
            ST_LOCKED: begin
               if (hit) begin
                  miss_d = 4'd0;
               end else begin
                  // Re-seeding from the bad value means a single glitch costs one error.
                  err_pulse_d = 1'b1;
                  if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                  if (miss_q + 4'd1 == LOSS_TGT) begin
                     state_d = ST_ACQ;
                     match_d = 4'd0;
                     miss_d  = 4'd0;
                  end else begin
                     miss_d = miss_q + 4'd1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               match_d = 4'd0;
               miss_d  = 4'd0;
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk or negedge rstn_n) begin
      if (!rstn_n) begin
         state_q     <= ST_IDLE;
         match_q     <= 4'd0;
         miss_q      <= 4'd0;
         err_count_q <= 8'd0;
         err_pulse_q <= 1'b0;
         locked_q    <= 1'b0;
         last_val_q  <= '0;
      end else begin
         state_q     <= state_d;
         match_q     <= match_d;
         miss_q      <= miss_d;
         err_count_q <= err_count_d;
         err_pulse_q <= err_pulse_d;
         locked_q    <= locked_d;
         last_val_q  <= last_val_d;
      end
   end

   assign state     = state_q;
   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign last_val  = last_val_q;

endmodule
